// File: rtl/full_adder_core.sv
// -----------------------------------------------------------------------------
// full_adder_core
//
// Purpose:
//   Ripple-carry adder computing a + b + cin. The sum and carry outputs are
//   purely combinational and feed downstream logic directly. A registered copy
//   of the result, qualified by a one-cycle out_valid pulse, serves clocked
//   consumers. WIDTH=1 is the classic single-bit full adder.
//
// Parameters:
//   WIDTH      operand width in bits (1..64)
//
// Ports:
//   clk        in   system clock, registers update on the rising edge
//   rst_n      in   asynchronous active-low reset
//   a, b       in   WIDTH-bit operands
//   cin        in   carry into bit 0
//   in_valid   in   qualifies a/b/cin for capture into the output register
//   sum        out  combinational (a + b + cin) mod 2^WIDTH
//   cout       out  combinational carry out of the MSB
//   sum_q      out  registered sum
//   cout_q     out  registered cout
//   out_valid  out  high for one cycle after each accepted in_valid
//
// Optional feature (macro FULL_ADDER_CORE_OVF_EN):
//   ovf        out  combinational two's-complement signed overflow
//   ovf_q      out  registered ovf, captured alongside sum_q
// -----------------------------------------------------------------------------
module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
`ifdef FULL_ADDER_CORE_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  // Carry chain: w_carry[0] is the carry in, w_carry[WIDTH] the carry out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
  end

  assign sum  = w_sum;
  assign cout = w_carry[WIDTH];

`ifdef FULL_ADDER_CORE_OVF_EN
  // Signed overflow: the carry into the sign bit differs from the carry out.
  logic w_ovf;
  logic r_ovf_q;

  assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];
  assign ovf   = w_ovf;
  assign ovf_q = r_ovf_q;
`endif

  logic [WIDTH-1:0] r_sum_q;
  logic             r_cout_q;
  logic             r_out_valid;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking assignments here would create order-dependent
  // simulation that does not match the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q     <= '0;
      r_cout_q    <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef FULL_ADDER_CORE_OVF_EN
      r_ovf_q     <= 1'b0;
`endif
    end else begin
      // out_valid is a single-cycle pulse per accepted input; the data
      // registers hold their last captured value when nothing is accepted.
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum_q  <= w_sum;
        r_cout_q <= w_carry[WIDTH];
`ifdef FULL_ADDER_CORE_OVF_EN
        r_ovf_q  <= w_ovf;
`endif
      end
    end
  end

  assign sum_q     = r_sum_q;
  assign cout_q    = r_cout_q;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_full_adder_core.sv
// -----------------------------------------------------------------------------
// tb_full_adder_core
//
// Self-checking bench for full_adder_core using directed vectors with
// hand-computed expectations. Three instances share clk/rst_n: WIDTH=1
// (truth table, registered path, async reset), WIDTH=4 (back-to-back capture)
// and WIDTH=8 (carry chain, boundaries, optional overflow output).
// -----------------------------------------------------------------------------
module tb_full_adder_core;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_failures;

  // WIDTH=1 instance
  logic a1, b1, cin1, iv1;
  logic sum1, cout1, sum_q1, cout_q1, ov1;

  // WIDTH=4 instance
  logic [3:0] a4, b4;
  logic       cin4, iv4;
  logic [3:0] sum4, sum_q4;
  logic       cout4, cout_q4, ov4;

  // WIDTH=8 instance
  logic [7:0] a8, b8;
  logic       cin8, iv8;
  logic [7:0] sum8, sum_q8;
  logic       cout8, cout_q8, ov8;

`ifdef FULL_ADDER_CORE_OVF_EN
  logic ovf1, ovf_q1, ovf4, ovf_q4, ovf8, ovf_q8;
`endif

  full_adder_core #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
    .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1), .out_valid(ov1)
`ifdef FULL_ADDER_CORE_OVF_EN
    , .ovf(ovf1), .ovf_q(ovf_q1)
`endif
  );

  full_adder_core #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
    .sum(sum4), .cout(cout4), .sum_q(sum_q4), .cout_q(cout_q4), .out_valid(ov4)
`ifdef FULL_ADDER_CORE_OVF_EN
    , .ovf(ovf4), .ovf_q(ovf_q4)
`endif
  );

  full_adder_core #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
    .sum(sum8), .cout(cout8), .sum_q(sum_q8), .cout_q(cout_q8), .out_valid(ov8)
`ifdef FULL_ADDER_CORE_OVF_EN
    , .ovf(ovf8), .ovf_q(ovf_q8)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // WIDTH=1 truth table indexed by {a,b,cin}, entries are {cout,sum}.
  localparam logic [1:0] TRUTH [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                                       2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_failures = 0;
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b0;
    a4 = '0;   b4 = '0;   cin4 = 1'b0; iv4 = 1'b0;
    a8 = '0;   b8 = '0;   cin8 = 1'b0; iv8 = 1'b0;

    // Reset state of the registered outputs.
    #2;
    check("rst_sum_q",     64'(sum_q1),  64'd0);
    check("rst_cout_q",    64'(cout_q1), 64'd0);
    check("rst_out_valid", 64'(ov1),     64'd0);

    // Exhaustive WIDTH=1 sweep, run while reset is held to show the
    // combinational path does not depend on reset or clock.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a1, b1, cin1} = v;
      #10;
      check($sformatf("tt_%0d%0d%0d", v[2], v[1], v[0]), 64'({cout1, sum1}), 64'(TRUTH[i]));
    end

    // Release reset away from a rising edge.
    @(negedge clk);
    rst_n = 1'b1;

    // Registered path: 1+1+0 -> sum_q=0, cout_q=1.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    check("reg_sum_q",     64'(sum_q1),  64'd0);
    check("reg_cout_q",    64'(cout_q1), 64'd1);
    check("reg_out_valid", 64'(ov1),     64'd1);
    @(negedge clk);
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1;
    @(posedge clk); #1;
    check("hold_out_valid", 64'(ov1),     64'd0);
    check("hold_sum_q",     64'(sum_q1),  64'd0);
    check("hold_cout_q",    64'(cout_q1), 64'd1);

    // Async reset while out_valid is high: capture 1+1+1 -> sum_q=1, cout_q=1.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_out_valid", 64'(ov1),    64'd1);
    check("pre_rst_sum_q",     64'(sum_q1), 64'd1);
    #2;
    rst_n = 1'b0;
    a1 = 1'b0;
    #1;
    check("arst_sum_q",     64'(sum_q1),  64'd0);
    check("arst_cout_q",    64'(cout_q1), 64'd0);
    check("arst_out_valid", 64'(ov1),     64'd0);
    // 0+1+1 -> sum=0, cout=1 while in reset.
    check("arst_comb", 64'({cout1, sum1}), 64'(2'b10));
    @(negedge clk);
    iv1 = 1'b0;
    rst_n = 1'b1;

    // WIDTH=8 carry chain and boundary vectors.
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #1;
    check("w8_ff_00_1", 64'({cout8, sum8}), 64'h100);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; #1;
    check("w8_7f_01_0", 64'({cout8, sum8}), 64'h080);
`ifdef FULL_ADDER_CORE_OVF_EN
    check("w8_ovf_7f_01", 64'(ovf8), 64'd1);
`endif
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; #1;
    check("w8_ff_01_0", 64'({cout8, sum8}), 64'h100);
`ifdef FULL_ADDER_CORE_OVF_EN
    check("w8_ovf_ff_01", 64'(ovf8), 64'd0);
`endif
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
    check("w8_all_ones", 64'({cout8, sum8}), 64'h1FF);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; #1;
    check("w8_all_zeros", 64'({cout8, sum8}), 64'h000);
    a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; #1;
    check("w8_a5_5a_1", 64'({cout8, sum8}), 64'h100);

    // WIDTH=8 registered capture of 0x80+0x80+0 -> sum_q=0x00, cout_q=1.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    check("w8_reg", 64'({cout_q8, sum_q8}), 64'h100);
`ifdef FULL_ADDER_CORE_OVF_EN
    check("w8_ovf_q", 64'(ovf_q8), 64'd1);
`endif
    @(negedge clk);
    iv8 = 1'b0;

    // WIDTH=4 back-to-back: a=0..3, b=1 -> sum_q=1..4 with out_valid held.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_sum;
      exp_sum = 4'(i + 1);
      a4 = 4'(i); b4 = 4'd1; cin4 = 1'b0; iv4 = 1'b1;
      @(posedge clk); #1;
      check($sformatf("b2b_sum_q_%0d", i), 64'(sum_q4), 64'(exp_sum));
      check($sformatf("b2b_valid_%0d", i), 64'(ov4),   64'd1);
      @(negedge clk);
    end
    iv4 = 1'b0; a4 = 4'd9;
    @(posedge clk); #1;
    check("b2b_end_valid", 64'(ov4),    64'd0);
    check("b2b_end_hold",  64'(sum_q4), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
